// File: rtl/ctrl_id_pipe.sv
// ctrl_id_pipe: instruction-decode stage controller with ID/EX pipeline register.
//   Decodes the IF/ID instruction into EX control bits, detects load-use hazards
//   against the load currently in EX, and inserts LOAD_STALL bubbles while
//   asserting a combinational stall that freezes PC and IF/ID.
//
// Parameters
//   LOAD_STALL  bubbles inserted per load-use hazard (1..3)
//   EN_EXT      1: decode ori/slti/lui/jal, 0: treat them as illegal
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid, instr   IF/ID instruction and its valid flag
//   flush             taken branch/jump; kill the instruction in ID
//   ex_mem_read_in    instruction in EX is a load
//   ex_rt_in          destination register of that load
//   stall             combinational; hold PC and IF/ID this cycle
//   ex_*              registered ID/EX control and register fields
//
// state | meaning
// IDLE  | decode normally; a hazard here starts a stall
// HOLD  | extra bubbles after the first one; cnt counts those still owed
module ctrl_id_pipe #(
  parameter int unsigned LOAD_STALL = 1,
  parameter bit          EN_EXT     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic        flush,
  input  logic        ex_mem_read_in,
  input  logic [4:0]  ex_rt_in,
  output logic        stall,
  output logic        ex_valid,
  output logic        ex_alusrc,
  output logic [2:0]  ex_aluop,
  output logic        ex_regdst,
  output logic        ex_branch_eq,
  output logic        ex_branch_ne,
  output logic        ex_memwrite,
  output logic        ex_memread,
  output logic        ex_memtoreg,
  output logic        ex_regwrite,
  output logic        ex_jump,
  output logic        ex_link,
  output logic        ex_illegal,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd
);

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;

  // First bubble is issued from IDLE, so HOLD owes the remaining LOAD_STALL-1.
  localparam logic [1:0] HOLD_CNT = 2'(LOAD_STALL - 1);

  typedef enum logic {IDLE, HOLD} stateT;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       aluSrc;
    logic [2:0] aluOp;
    logic       regDst;
    logic       branchEq;
    logic       branchNe;
    logic       memWrite;
    logic       memRead;
    logic       memToReg;
    logic       regWrite;
    logic       jump;
    logic       link;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } idExT;

  stateT      state, stateNxt;
  logic [1:0] cnt, cntNxt;
  idExT       dec, exReg;
  logic       takeInstr;
  logic       useRs, useRt, hazard;

  logic [5:0] op;
  logic [4:0] rs, rt;
  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rs    = rs;
    dec.rt    = rt;
    dec.rd    = instr[15:11];
    case (op)
      6'b000000: begin dec.regDst = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_FUNCT; end
      6'b100011: begin
        dec.aluSrc = 1'b1; dec.memRead = 1'b1; dec.memToReg = 1'b1;
        dec.regWrite = 1'b1; dec.aluOp = ALU_ADD;
      end
      6'b101011: begin dec.aluSrc = 1'b1; dec.memWrite = 1'b1; dec.aluOp = ALU_ADD; end
      6'b001000: begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_ADD; end
      6'b001100: begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_AND; end
      6'b000100: begin dec.branchEq = 1'b1; dec.aluOp = ALU_SUB; end
      6'b000101: begin dec.branchNe = 1'b1; dec.aluOp = ALU_SUB; end
      6'b000010: dec.jump = 1'b1;
      6'b001101: begin
        if (EN_EXT) begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_OR; end
        else dec.illegal = 1'b1;
      end
      6'b001010: begin
        if (EN_EXT) begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_SLT; end
        else dec.illegal = 1'b1;
      end
      6'b001111: begin
        if (EN_EXT) begin dec.aluSrc = 1'b1; dec.regWrite = 1'b1; dec.aluOp = ALU_LUI; end
        else dec.illegal = 1'b1;
      end
      6'b000011: begin
        if (EN_EXT) begin
          dec.jump = 1'b1; dec.link = 1'b1; dec.regWrite = 1'b1; dec.regDst = 1'b1;
          dec.rd = 5'd31;
        end else dec.illegal = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // Source usage is a property of the opcode, independent of EN_EXT.
  assign useRs  = !(op == 6'b000010 || op == 6'b000011);
  assign useRt  = (op == 6'b000000) || (op == 6'b101011) ||
                  (op == 6'b000100) || (op == 6'b000101);
  assign hazard = in_valid && ex_mem_read_in && (ex_rt_in != 5'd0) &&
                  ((useRs && ex_rt_in == rs) || (useRt && ex_rt_in == rt));

  always_comb begin
    stateNxt  = state;
    cntNxt    = cnt;
    stall     = 1'b0;
    takeInstr = 1'b0;
    if (!rst_n) begin
      stateNxt = IDLE;
      cntNxt   = 2'd0;
    end else if (flush) begin
      stateNxt = IDLE;
      cntNxt   = 2'd0;
    end else if (state == HOLD) begin
      stall = 1'b1;
      if (cnt <= 2'd1) begin
        stateNxt = IDLE;
        cntNxt   = 2'd0;
      end else begin
        cntNxt = cnt - 2'd1;
      end
    end else if (hazard) begin
      stall = 1'b1;
      if (LOAD_STALL > 1) begin
        stateNxt = HOLD;
        cntNxt   = HOLD_CNT;
      end
    end else begin
      takeInstr = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
      exReg <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
      exReg <= takeInstr ? dec : '0;
    end
  end

  assign ex_valid     = exReg.valid;
  assign ex_illegal   = exReg.illegal;
  assign ex_alusrc    = exReg.aluSrc;
  assign ex_aluop     = exReg.aluOp;
  assign ex_regdst    = exReg.regDst;
  assign ex_branch_eq = exReg.branchEq;
  assign ex_branch_ne = exReg.branchNe;
  assign ex_memwrite  = exReg.memWrite;
  assign ex_memread   = exReg.memRead;
  assign ex_memtoreg  = exReg.memToReg;
  assign ex_regwrite  = exReg.regWrite;
  assign ex_jump      = exReg.jump;
  assign ex_link      = exReg.link;
  assign ex_rs        = exReg.rs;
  assign ex_rt        = exReg.rt;
  assign ex_rd        = exReg.rd;

endmodule

// File: tb/tb_ctrl_id_pipe.sv
// tb_ctrl_id_pipe: three instances (LOAD_STALL/EN_EXT = 1/0, 2/1, 3/1) share one
// stimulus stream; each is compared every cycle against a bubble-count model.
module tb_ctrl_id_pipe;

  logic        clk = 1'b0;
  logic        rstN, inValid, flushIn, exMemRead;
  logic [31:0] instrIn;
  logic [4:0]  exRtIn;

  // {valid, illegal, alusrc, aluop[2:0], regdst, beq, bne, memwrite, memread,
  //  memtoreg, regwrite, jump, link, rs, rt, rd}
  wire [29:0] exVec [3];
  wire        stallW [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gInst
    logic       stall, exValid, exAluSrc, exRegDst, exBeq, exBne, exMemWr, exMemRd;
    logic       exMemToReg, exRegWr, exJump, exLink, exIllegal;
    logic [2:0] exAluOp;
    logic [4:0] exRs, exRt, exRd;
    ctrl_id_pipe #(.LOAD_STALL(g + 1), .EN_EXT(g > 0 ? 1'b1 : 1'b0)) dut (
      .clk(clk), .rst_n(rstN), .in_valid(inValid), .instr(instrIn), .flush(flushIn),
      .ex_mem_read_in(exMemRead), .ex_rt_in(exRtIn), .stall(stall),
      .ex_valid(exValid), .ex_alusrc(exAluSrc), .ex_aluop(exAluOp), .ex_regdst(exRegDst),
      .ex_branch_eq(exBeq), .ex_branch_ne(exBne), .ex_memwrite(exMemWr),
      .ex_memread(exMemRd), .ex_memtoreg(exMemToReg), .ex_regwrite(exRegWr),
      .ex_jump(exJump), .ex_link(exLink), .ex_illegal(exIllegal),
      .ex_rs(exRs), .ex_rt(exRt), .ex_rd(exRd)
    );
    assign exVec[g] = {exValid, exIllegal, exAluSrc, exAluOp, exRegDst, exBeq, exBne,
                       exMemWr, exMemRd, exMemToReg, exRegWr, exJump, exLink,
                       exRs, exRt, exRd};
    assign stallW[g] = stall;
  end

  int   checkCnt = 0;
  int   passCnt  = 0;
  int   holdLeft [3];
  logic obsStall [3];

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [29:0] expDecode(input logic [31:0] ins, input bit ext);
    logic ill, src, rdst, beq, bne, mw, mr, m2r, rw, jmp, lnk;
    logic [2:0] alu;
    logic [4:0] rd;
    {ill, src, rdst, beq, bne, mw, mr, m2r, rw, jmp, lnk} = '0;
    alu = 3'd0;
    rd  = ins[15:11];
    case (ins[31:26])
      6'h00: begin rdst = 1; rw = 1; alu = 3'd2; end
      6'h23: begin src = 1; mr = 1; m2r = 1; rw = 1; end
      6'h2b: begin src = 1; mw = 1; end
      6'h08: begin src = 1; rw = 1; end
      6'h0c: begin src = 1; rw = 1; alu = 3'd3; end
      6'h04: begin beq = 1; alu = 3'd1; end
      6'h05: begin bne = 1; alu = 3'd1; end
      6'h02: jmp = 1;
      6'h0d: if (ext) begin src = 1; rw = 1; alu = 3'd4; end else ill = 1;
      6'h0a: if (ext) begin src = 1; rw = 1; alu = 3'd5; end else ill = 1;
      6'h0f: if (ext) begin src = 1; rw = 1; alu = 3'd6; end else ill = 1;
      6'h03: if (ext) begin jmp = 1; lnk = 1; rw = 1; rdst = 1; rd = 5'd31; end else ill = 1;
      default: ill = 1;
    endcase
    return {1'b1, ill, src, alu, rdst, beq, bne, mw, mr, m2r, rw, jmp, lnk,
            ins[25:21], ins[20:16], rd};
  endfunction

  function automatic bit hazardOf();
    logic [5:0] op;
    bit usesRs, usesRt;
    op     = instrIn[31:26];
    usesRs = !(op == 6'h02 || op == 6'h03);
    usesRt = (op == 6'h00 || op == 6'h2b || op == 6'h04 || op == 6'h05);
    return inValid && exMemRead && exRtIn != 0 &&
           ((usesRs && exRtIn == instrIn[25:21]) || (usesRt && exRtIn == instrIn[20:16]));
  endfunction

  // holdLeft = bubbles still owed after the current one.
  task automatic modelCycle(input int k, output logic s, output logic [29:0] v);
    s = 1'b0;
    v = '0;
    if (!rstN || flushIn) holdLeft[k] = 0;
    else if (holdLeft[k] > 0) begin s = 1'b1; holdLeft[k]--; end
    else if (hazardOf()) begin s = 1'b1; holdLeft[k] = k; end
    else if (inValid) v = expDecode(instrIn, k > 0);
  endtask

  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic fl, input logic mr, input logic [4:0] rtIn);
    logic       expStall [3];
    logic [29:0] expEx [3];
    @(negedge clk);
    rstN = r; inValid = iv; instrIn = ins; flushIn = fl; exMemRead = mr; exRtIn = rtIn;
    for (int k = 0; k < 3; k++) modelCycle(k, expStall[k], expEx[k]);
    #1;
    for (int k = 0; k < 3; k++) begin
      obsStall[k] = stallW[k];
      checkVal($sformatf("stall%0d", k), {31'd0, stallW[k]}, {31'd0, expStall[k]});
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      checkVal($sformatf("ex%0d", k), {2'd0, exVec[k]}, {2'd0, expEx[k]});
  endtask

  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] ADD  = 32'h00431020;
  localparam logic [31:0] JAL  = 32'h0C000010;
  localparam logic [31:0] ADDI = 32'h20050001;

  logic [5:0] opPool [15];

  initial begin
    logic [31:0] ins;
    opPool = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h0c, 6'h04, 6'h05, 6'h02,
               6'h0d, 6'h0a, 6'h0f, 6'h03, 6'h01, 6'h3f, 6'h20};
    for (int k = 0; k < 3; k++) holdLeft[k] = 0;
    rstN = 1'b0; inValid = 1'b1; instrIn = LW; flushIn = 1'b0; exMemRead = 1'b1; exRtIn = 5'd1;

    step(0, 1, LW, 0, 1, 1);
    step(0, 1, LW, 0, 1, 1);
    checkVal("rstEx", {2'd0, exVec[1]}, 32'd0);
    checkVal("rstStall", {31'd0, obsStall[1]}, 32'd0);

    step(1, 1, LW, 0, 0, 0);
    checkVal("lwMemRd", {31'd0, exVec[1][19]}, 32'd1);
    checkVal("lwMemToReg", {31'd0, exVec[1][18]}, 32'd1);
    checkVal("lwRegWr", {31'd0, exVec[1][17]}, 32'd1);
    checkVal("lwAluSrc", {31'd0, exVec[1][27]}, 32'd1);
    checkVal("lwAluOp", {29'd0, exVec[1][26:24]}, 32'd0);
    checkVal("lwRt", {27'd0, exVec[1][9:5]}, 32'd2);

    step(1, 1, ADD, 0, 1, 2);
    checkVal("luStall1", {31'd0, obsStall[1]}, 32'd1);
    checkVal("luBubble1", {31'd0, exVec[1][29]}, 32'd0);
    step(1, 1, ADD, 0, 0, 0);
    checkVal("luStall2", {31'd0, obsStall[1]}, 32'd1);
    checkVal("luBubble2", {31'd0, exVec[1][29]}, 32'd0);
    step(1, 1, ADD, 0, 0, 0);
    checkVal("luStall3", {31'd0, obsStall[1]}, 32'd0);
    checkVal("luAluOp", {29'd0, exVec[1][26:24]}, 32'd2);
    step(1, 0, 32'd0, 1, 0, 0);

    step(1, 1, ADD, 0, 1, 2);
    step(1, 1, ADD, 1, 0, 0);
    checkVal("flStall", {31'd0, obsStall[1]}, 32'd0);
    checkVal("flBubble", {2'd0, exVec[1]}, 32'd0);
    step(1, 1, ADD, 0, 0, 0);
    checkVal("flIdle", {31'd0, exVec[1][29]}, 32'd1);

    step(1, 1, JAL, 0, 0, 0);
    checkVal("jalJump", {31'd0, exVec[1][16]}, 32'd1);
    checkVal("jalLink", {31'd0, exVec[1][15]}, 32'd1);
    checkVal("jalRegWr", {31'd0, exVec[1][17]}, 32'd1);
    checkVal("jalRd", {27'd0, exVec[1][4:0]}, 32'd31);
    checkVal("jalIllegal", {31'd0, exVec[0][28]}, 32'd1);
    checkVal("jalCtrl0", {19'd0, exVec[0][27:15]}, 32'd0);

    step(1, 1, ADDI, 0, 1, 0);
    checkVal("rt0Stall", {31'd0, obsStall[2]}, 32'd0);

    step(1, 1, ADD, 0, 1, 2);
    step(0, 1, ADD, 0, 1, 2);
    step(1, 1, ADD, 0, 0, 0);
    checkVal("rstHoldStall", {31'd0, obsStall[2]}, 32'd0);
    checkVal("rstHoldValid", {31'd0, exVec[2][29]}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[31:26] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 14)];
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      step($urandom_range(0, 40) != 0, $urandom_range(0, 4) != 0, ins,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/ctrl_id_pipe.md
CTRL_ID_PIPE -- requirements
Module: ctrl_id_pipe

Interface
REQ-001 SHALL have parameter LOAD_STALL, default 1, giving load-use bubble count (legal 1..3).
REQ-002 SHALL have parameter EN_EXT, default 1; 1 enables ori/slti/lui/jal decode, 0 treats them as illegal.
REQ-003 SHALL have one clock; reset is synchronous and active-low, ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  IF/ID holds a valid instruction.
REQ-007 instr  input  32  instruction: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11].
REQ-008 flush  input  1  branch/jump resolved taken; kill instruction in ID.
REQ-009 ex_mem_read_in  input  1  instruction currently in EX is a load.
REQ-010 ex_rt_in  input  5  destination register of the load in EX.
REQ-011 stall  output  1  combinational; freeze PC and IF/ID this cycle.
REQ-012 Registered ID/EX outputs: ex_valid 1, ex_alusrc 1, ex_aluop 3, ex_regdst 1, ex_branch_eq 1, ex_branch_ne 1, ex_memwrite 1, ex_memread 1, ex_memtoreg 1, ex_regwrite 1, ex_jump 1, ex_link 1, ex_illegal 1, ex_rs 5, ex_rt 5, ex_rd 5.

Function
REQ-013 ex_aluop encoding SHALL be: 000 add, 001 sub, 010 funct-decode, 011 and, 100 or, 101 slt, 110 lui.
REQ-014 Decode SHALL be: R 000000 {regdst,regwrite,aluop=010}; lw 100011 {alusrc,memread,memtoreg,regwrite,add}; sw 101011 {alusrc,memwrite,add}; addi 001000 {alusrc,regwrite,add}; andi 001100 {alusrc,regwrite,and}; beq 000100 {branch_eq,sub}; bne 000101 {branch_ne,sub}; j 000010 {jump}.
REQ-015 With EN_EXT=1: ori 001101 {alusrc,regwrite,or}; slti 001010 {alusrc,regwrite,slt}; lui 001111 {alusrc,regwrite,lui}; jal 000011 {jump,link,regwrite,regdst, ex_rd=31}.
REQ-016 Unlisted opcode (or ext opcode with EN_EXT=0) SHALL register all control bits 0, ex_valid=1, ex_illegal=1.
REQ-017 Bubble = ex_valid 0, every control bit and ex_illegal 0, ex_rs/ex_rt/ex_rd 0.
REQ-018 Instruction uses rt as source for R, sw, beq, bne only; uses rs for all except j, jal.
REQ-019 Hazard = in_valid & ex_mem_read_in & ex_rt_in!=0 & (ex_rt_in==rs used | ex_rt_in==rt used).
REQ-020 FSM states IDLE, HOLD; 2-bit counter cnt.
REQ-021 IDLE, no flush, no hazard: stall=0; decoded instruction registered next edge (latency 1), or bubble if in_valid=0.
REQ-022 IDLE, hazard, no flush: stall=1, bubble registered; if LOAD_STALL>1 go HOLD with cnt=LOAD_STALL-1, else stay IDLE.
REQ-023 HOLD: stall=1, bubble registered, cnt decrements; cnt==1 -> IDLE next; hazard inputs ignored in HOLD.
REQ-024 flush SHALL take priority over hazard and HOLD: stall=0, bubble registered, state IDLE, cnt=0.
REQ-025 After a stall ends, the held instruction SHALL re-evaluate hazard normally in IDLE.
REQ-026 ex_rd SHALL be instr rd for all non-jal opcodes, regardless of regdst.

Reset
REQ-027 rst_n=0 at a rising edge SHALL force bubble on all registered outputs, state IDLE, cnt=0.
REQ-028 stall SHALL be 0 while rst_n=0 and in the first cycle after reset unless a hazard is present in IDLE.
REQ-029 Reset mid-HOLD SHALL abort the stall with no further bubbles.

Verification
REQ-030 Reset: rst_n=0 two cycles, instr=0x8C220004 -> all ex_* 0, stall 0.
REQ-031 lw decode: instr=0x8C220004, in_valid=1 -> next cycle ex_memread=1, ex_memtoreg=1, ex_regwrite=1, ex_alusrc=1, ex_aluop=000, ex_rt=2.
REQ-032 Load-use, LOAD_STALL=2: ex_mem_read_in=1, ex_rt_in=2, instr add rs=2 (0x00431020) -> stall=1 two cycles, two bubbles, then R-type registered with ex_aluop=010.
REQ-033 Flush during HOLD: flush=1 in second stall cycle -> stall=0 that cycle, bubble, state IDLE.
REQ-034 jal, EN_EXT=1: instr=0x0C000010 -> ex_jump=1, ex_link=1, ex_regwrite=1, ex_rd=31; EN_EXT=0 -> ex_illegal=1, all control 0.
REQ-035 ex_rt_in=0 with ex_mem_read_in=1 and rs=0 -> stall=0.
